// File: rtl/bpd_tourn_if.sv
// Fetch/commit bus of the tournament branch predictor. The master side drives the F1 lookup
// and commit packet; the slave side (the predictor) returns the prediction and stats.
interface bpd_tourn_if #(
    parameter int GHIST_W = 12,
    parameter int LHIST_W = 10
);
    logic               flush;
    logic [63:0]        pc_f1;
    logic [63:0]        pc_f1_t;
    logic [63:0]        pc_f1_nt;
    logic               btb_brdir;
    logic               cond_br;
    logic [LHIST_W-1:0] lochist;
    logic               ready;
    logic               pred;
    logic               gpred;
    logic               lpred;
    logic [GHIST_W-1:0] ghist;
    logic               override;
    logic [63:0]        override_pc;
    logic               cm_valid;
    logic [63:0]        cm_pc;
    logic [GHIST_W-1:0] cm_ghist;
    logic [LHIST_W-1:0] cm_lochist;
    logic               cm_brdir;
    logic               cm_gpred;
    logic               cm_lpred;
    logic               cm_fpred;
    logic [31:0]        stat_cnt;
    logic [31:0]        stat_misp;

    modport master (
        output flush, pc_f1, pc_f1_t, pc_f1_nt, btb_brdir, cond_br, lochist,
               cm_valid, cm_pc, cm_ghist, cm_lochist, cm_brdir, cm_gpred, cm_lpred, cm_fpred,
        input  ready, pred, gpred, lpred, ghist, override, override_pc, stat_cnt, stat_misp
    );

    modport slave (
        input  flush, pc_f1, pc_f1_t, pc_f1_nt, btb_brdir, cond_br, lochist,
               cm_valid, cm_pc, cm_ghist, cm_lochist, cm_brdir, cm_gpred, cm_lpred, cm_fpred,
        output ready, pred, gpred, lpred, ghist, override, override_pc, stat_cnt, stat_misp
    );
endinterface

// File: rtl/bpd_tourn.sv
// Tournament conditional-branch predictor (gshare + local + choice) with speculative global history.
// Define BPD_STATS_EN to build the saturating commit / misprediction counters.
module bpd_tourn #(
    parameter int GHIST_W = 12,
    parameter int LHIST_W = 10,
    parameter int GCNT_W  = 2,
    parameter int LCNT_W  = 3,
    parameter int CCNT_W  = 2
) (
    input  logic       clock,
    input  logic       reset,
    bpd_tourn_if.slave bus
);
    localparam int GDEPTH = 1 << GHIST_W;
    localparam int LDEPTH = 1 << LHIST_W;
    // Every counter starts one step below the taken/global threshold.
    localparam logic [GCNT_W-1:0] G_INIT = GCNT_W'((1 << (GCNT_W-1)) - 1);
    localparam logic [LCNT_W-1:0] L_INIT = LCNT_W'((1 << (LCNT_W-1)) - 1);
    localparam logic [CCNT_W-1:0] C_INIT = CCNT_W'((1 << (CCNT_W-1)) - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_nxt;
    logic [GHIST_W-1:0] idx, idx_nxt;
    logic               ready;

    logic [GCNT_W-1:0]  g_pht [GDEPTH];
    logic [LCNT_W-1:0]  l_pht [LDEPTH];
    logic [CCNT_W-1:0]  c_pht [GDEPTH];

    logic [GHIST_W-1:0] ghist;
    logic [GHIST_W-1:0] gidx;
    logic               g_raw, l_raw, c_raw, pred_raw;

    logic               upd_vld, upd_dir, upd_csel, upd_cup;
    logic [GHIST_W-1:0] upd_gidx, upd_cidx;
    logic [LHIST_W-1:0] upd_lidx;
    logic [GCNT_W-1:0]  g_cur, g_new;
    logic [LCNT_W-1:0]  l_cur, l_new;
    logic [CCNT_W-1:0]  c_cur, c_new;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == INIT) begin
            idx_nxt = idx + 1'b1;
            if (idx == '1) state_nxt = RUN;
        end
    end

    assign ready = (state == RUN);

    assign gidx     = bus.pc_f1[GHIST_W+1:2] ^ ghist;
    assign g_raw    = g_pht[gidx][GCNT_W-1];
    assign l_raw    = l_pht[bus.lochist][LCNT_W-1];
    assign c_raw    = c_pht[ghist][CCNT_W-1];
    assign pred_raw = c_raw ? g_raw : l_raw;

    assign bus.ready       = ready;
    assign bus.gpred       = ready & g_raw;
    assign bus.lpred       = ready & l_raw;
    assign bus.pred        = ready & pred_raw;
    assign bus.ghist       = ghist;
    assign bus.override    = (bus.btb_brdir ^ pred_raw) & bus.cond_br & ready;
    assign bus.override_pc = ready ? (pred_raw ? bus.pc_f1_t : bus.pc_f1_nt) : 64'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upd_vld  <= 1'b0;
            upd_dir  <= 1'b0;
            upd_csel <= 1'b0;
            upd_cup  <= 1'b0;
            upd_gidx <= '0;
            upd_cidx <= '0;
            upd_lidx <= '0;
        end else begin
            upd_vld  <= bus.cm_valid & ready;
            upd_dir  <= bus.cm_brdir;
            upd_csel <= bus.cm_gpred ^ bus.cm_lpred;
            upd_cup  <= (bus.cm_gpred == bus.cm_brdir);
            upd_gidx <= bus.cm_pc[GHIST_W+1:2] ^ bus.cm_ghist;
            upd_cidx <= bus.cm_ghist;
            upd_lidx <= bus.cm_lochist;
        end
    end

    // Read-modify-write happens in the write cycle, so back-to-back commits chain correctly.
    always_comb begin
        g_cur = g_pht[upd_gidx];
        l_cur = l_pht[upd_lidx];
        c_cur = c_pht[upd_cidx];
        g_new = upd_dir ? ((g_cur == '1) ? g_cur : g_cur + 1'b1)
                        : ((g_cur == '0) ? g_cur : g_cur - 1'b1);
        l_new = upd_dir ? ((l_cur == '1) ? l_cur : l_cur + 1'b1)
                        : ((l_cur == '0) ? l_cur : l_cur - 1'b1);
        c_new = upd_cup ? ((c_cur == '1) ? c_cur : c_cur + 1'b1)
                        : ((c_cur == '0) ? c_cur : c_cur - 1'b1);
    end

    always_ff @(posedge clock) begin
        if (state == INIT) begin
            g_pht[idx] <= G_INIT;
            c_pht[idx] <= C_INIT;
            if ((idx >> LHIST_W) == '0) l_pht[idx[LHIST_W-1:0]] <= L_INIT;
        end else if (upd_vld) begin
            g_pht[upd_gidx] <= g_new;
            l_pht[upd_lidx] <= l_new;
            if (upd_csel) c_pht[upd_cidx] <= c_new;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghist <= '0;
        end else if (ready) begin
            if (bus.flush && bus.cm_valid) ghist <= {bus.cm_ghist[GHIST_W-2:0], bus.cm_brdir};
            else if (bus.flush)            ghist <= bus.cm_ghist;
            else if (bus.cond_br)          ghist <= {ghist[GHIST_W-2:0], pred_raw};
        end
    end

`ifdef BPD_STATS_EN
    logic [31:0] stat_cnt, stat_misp;
    logic        unused_bits;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_cnt  <= '0;
            stat_misp <= '0;
        end else if (bus.cm_valid && ready) begin
            if (stat_cnt != '1) stat_cnt <= stat_cnt + 1'b1;
            if ((bus.cm_fpred != bus.cm_brdir) && (stat_misp != '1)) stat_misp <= stat_misp + 1'b1;
        end
    end

    assign bus.stat_cnt  = stat_cnt;
    assign bus.stat_misp = stat_misp;
    assign unused_bits   = ^{bus.pc_f1[63:GHIST_W+2], bus.pc_f1[1:0],
                             bus.cm_pc[63:GHIST_W+2], bus.cm_pc[1:0]};
`else
    logic unused_bits;

    assign bus.stat_cnt  = 32'd0;
    assign bus.stat_misp = 32'd0;
    assign unused_bits   = ^{bus.pc_f1[63:GHIST_W+2], bus.pc_f1[1:0],
                             bus.cm_pc[63:GHIST_W+2], bus.cm_pc[1:0], bus.cm_fpred};
`endif
endmodule

// File: tb/tb_bpd_tourn.sv
// Directed bench for bpd_tourn at GHIST_W=4, LHIST_W=3: init sweep, lookup vectors,
// counter training/saturation, choice selection, ghist flush priority, restart in RUN.
module tb_bpd_tourn;
    localparam int GW = 4;
    localparam int LW = 3;
`ifdef BPD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    int   exp_misp = 0;

    bpd_tourn_if #(.GHIST_W(GW), .LHIST_W(LW)) bus ();

    bpd_tourn #(.GHIST_W(GW), .LHIST_W(LW), .GCNT_W(2), .LCNT_W(3), .CCNT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]   pc;
        logic [LW-1:0] lh;
        logic          cond;
        logic          btb;
        logic [63:0]   t;
        logic [63:0]   nt;
        logic          pred;
        logic          ovr;
        logic [63:0]   opc;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One-cycle commit (optionally with flush); updates the expected stats when built in.
    task automatic do_commit(input logic [63:0] pc, input logic [GW-1:0] gh, input logic [LW-1:0] lh,
                             input logic dir, input logic gp, input logic lp, input logic fp,
                             input logic fl);
        bus.cm_valid   = 1'b1;
        bus.cm_pc      = pc;
        bus.cm_ghist   = gh;
        bus.cm_lochist = lh;
        bus.cm_brdir   = dir;
        bus.cm_gpred   = gp;
        bus.cm_lpred   = lp;
        bus.cm_fpred   = fp;
        bus.flush      = fl;
        if (STATS_EN) begin
            exp_cnt++;
            if (fp != dir) exp_misp++;
        end
        step();
        bus.cm_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.pc_f1      = '0;
        bus.pc_f1_t    = '0;
        bus.pc_f1_nt   = '0;
        bus.btb_brdir  = 1'b0;
        bus.cond_br    = 1'b0;
        bus.lochist    = '0;
        bus.cm_valid   = 1'b0;
        bus.cm_pc      = '0;
        bus.cm_ghist   = '0;
        bus.cm_lochist = '0;
        bus.cm_brdir   = 1'b0;
        bus.cm_gpred   = 1'b0;
        bus.cm_lpred   = 1'b0;
        bus.cm_fpred   = 1'b0;

        // pc, lochist, cond, btb, taken, fall-through, pred, override, override_pc (fresh tables)
        vecs[0] = '{64'h0,    3'd0, 1'b0, 1'b0, 64'h100, 64'h104, 1'b0, 1'b0, 64'h104};
        vecs[1] = '{64'h44,   3'd5, 1'b1, 1'b1, 64'h200, 64'h48,  1'b0, 1'b1, 64'h48};
        vecs[2] = '{64'h3C,   3'd7, 1'b1, 1'b0, 64'h300, 64'h40,  1'b0, 1'b0, 64'h40};
        vecs[3] = '{64'h1238, 3'd2, 1'b0, 1'b1, 64'h400, 64'h123C,1'b0, 1'b0, 64'h123C};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 3'd6, 1'b1, 1'b1, 64'h500, 64'h0, 1'b0, 1'b1, 64'h0};
        vecs[5] = '{64'h8,    3'd3, 1'b0, 1'b0, 64'h600, 64'hC,   1'b0, 1'b0, 64'hC};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Init sweep: 16 cycles not ready, ready on cycle 16
        chk("init_ready_c0", bus.ready, 1'b0);
        chk("init_pred_c0", bus.pred, 1'b0);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("init_ready_c%0d", k), bus.ready, 1'b0);
            chk($sformatf("init_pred_c%0d", k), bus.pred, 1'b0);
        end
        step();
        chk("init_ready_c16", bus.ready, 1'b1);
        chk("init_ghist", bus.ghist, 4'h0);
        chk("init_stat_cnt", bus.stat_cnt, 32'd0);

        for (int i = 0; i < 6; i++) begin
            bus.pc_f1     = vecs[i].pc;
            bus.lochist   = vecs[i].lh;
            bus.cond_br   = vecs[i].cond;
            bus.btb_brdir = vecs[i].btb;
            bus.pc_f1_t   = vecs[i].t;
            bus.pc_f1_nt  = vecs[i].nt;
            #1;
            chk($sformatf("vec%0d_pred", i), bus.pred, vecs[i].pred);
            chk($sformatf("vec%0d_override", i), bus.override, vecs[i].ovr);
            chk($sformatf("vec%0d_override_pc", i), bus.override_pc, vecs[i].opc);
            step();
        end
        bus.cond_br   = 1'b0;
        bus.btb_brdir = 1'b0;
        chk("vec_ghist_zero", bus.ghist, 4'h0);

        // Local/gshare training on L[5] and G[F]
        bus.pc_f1   = 64'h3C;
        bus.lochist = 3'd5;
        do_commit(64'h3C, 4'h0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("no_bypass_lpred", bus.lpred, 1'b0);
        step();
        chk("l5_one_taken", bus.lpred, 1'b1);
        chk("gF_one_taken", bus.gpred, 1'b1);
        for (int k = 0; k < 5; k++) do_commit(64'h3C, 4'h0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("l5_sat_top", bus.lpred, 1'b1);
        for (int k = 0; k < 3; k++) do_commit(64'h3C, 4'h0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("l5_held_at_max", bus.lpred, 1'b1);
        do_commit(64'h3C, 4'h0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("l5_down_to_011", bus.lpred, 1'b0);
        chk("gF_sat_bottom", bus.gpred, 1'b0);

        // Choice: C[A] 01 -> 10, then ghist=A selects gshare
        do_commit(64'h0, 4'hA, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        bus.flush    = 1'b1;
        bus.cm_ghist = 4'hA;
        step();
        bus.flush = 1'b0;
        chk("flush_alone_ghist", bus.ghist, 4'hA);
        bus.pc_f1   = 64'h0;
        bus.lochist = 3'd5;
        #1;
        chk("choice_gpred", bus.gpred, 1'b1);
        chk("choice_lpred", bus.lpred, 1'b0);
        chk("choice_pred", bus.pred, 1'b1);
        bus.pc_f1_t   = 64'h1000;
        bus.pc_f1_nt  = 64'h2000;
        bus.btb_brdir = 1'b0;
        bus.cond_br   = 1'b1;
        #1;
        chk("override_cond", bus.override, 1'b1);
        chk("override_pc_taken", bus.override_pc, 64'h1000);
        bus.cond_br = 1'b0;
        #1;
        chk("override_nocond", bus.override, 1'b0);

        // Three taken predictions then flush+commit beating a same-cycle cond_br
        bus.flush    = 1'b1;
        bus.cm_ghist = 4'h0;
        step();
        bus.flush = 1'b0;
        chk("flush_to_zero", bus.ghist, 4'h0);
        bus.lochist = 3'd0;
        bus.cond_br = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("spec_pred%0d", k), bus.pred, 1'b1);
            step();
        end
        chk("ghist_three_taken", bus.ghist, 4'h7);
        do_commit(64'h0, 4'h2, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flush_commit_ghist", bus.ghist, 4'h4);
        bus.cond_br = 1'b0;
        step();
        chk("stat_cnt", bus.stat_cnt, 32'(exp_cnt));
        chk("stat_misp", bus.stat_misp, 32'(exp_misp));

        // Reset in RUN restarts init; commits during init are dropped
        reset = 1'b1;
        #1;
        chk("rst_ready", bus.ready, 1'b0);
        chk("rst_ghist", bus.ghist, 4'h0);
        chk("rst_lpred_gated", bus.lpred, 1'b0);
        chk("rst_stat_cnt", bus.stat_cnt, 32'd0);
        bus.cm_valid   = 1'b1;
        bus.cm_pc      = 64'h0;
        bus.cm_ghist   = 4'h0;
        bus.cm_lochist = 3'd0;
        bus.cm_brdir   = 1'b1;
        bus.cm_gpred   = 1'b0;
        bus.cm_lpred   = 1'b0;
        bus.cm_fpred   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k < 16; k++) step();
        chk("reinit_ready_c15", bus.ready, 1'b0);
        step();
        chk("reinit_ready_c16", bus.ready, 1'b1);
        bus.cm_valid = 1'b0;
        step();
        chk("reinit_commit_dropped", bus.lpred, 1'b0);
        chk("reinit_stats_dropped", bus.stat_cnt, 32'd0);
        chk("reinit_ghist", bus.ghist, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
